// File: rtl/pipe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pipe_pkg                                                    |
// | Purpose  : Shared types, default geometry and helpers for the          |
// |            scrolling pipe field.                                       |
// | Contents : DEF_* geometry defaults, pipe_field_t (default-sized field), |
// |            clamp_gap() which keeps a gap fully inside the matrix.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package pipe_pkg;

  localparam int DEF_ROWS     = 16;
  localparam int DEF_COLS     = 16;
  localparam int DEF_GAP_H    = 4;
  localparam int DEF_PIPE_W   = 2;
  localparam int DEF_SPACING  = 6;
  localparam int DEF_BIRD_COL = 12;

  // Field laid out as [row][column] for the default matrix size.
  typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0] pipe_field_t;

  // The highest legal gap top is rows-gap_h; larger requests are pinned there
  // so the whole gap stays on screen.
  function automatic int clamp_gap(input int gap, input int rows, input int gap_h);
    return (gap > rows - gap_h) ? (rows - gap_h) : gap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_column_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pipe_column_gen                                             |
// | Purpose  : Combinational builder of the column injected at the entry   |
// |            edge: solid pipe except GAP_H open rows from gap_eff down.  |
// | Ports    : gap_eff (in)  top row of the gap                            |
// |            enable  (in)  1 = draw a pipe column, 0 = empty column      |
// |            column  (out) ROWS-bit column, 1 = pipe pixel               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module pipe_column_gen #(
  parameter int ROWS  = 16,
  parameter int GAP_H = 4
) (
  input  logic [$clog2(ROWS)-1:0] gap_eff,
  input  logic                    enable,
  output logic [ROWS-1:0]         column
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign column[r] = enable && !((r >= int'(gap_eff)) && (r < int'(gap_eff) + GAP_H));
  end

endmodule
`default_nettype wire

// File: rtl/pipe_scroller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pipe_scroller                                               |
// | Purpose  : Scrolling pipe field for the LED-matrix Flappy Bird game.   |
// |            Advances one column per qualified tick, spawns pipes every  |
// |            SPACING ticks with a random gap, flags bird passes.         |
// | Ports    : clk, reset (async, active-high)                             |
// |            tick, run, clear    scroll control                          |
// |            gap_top / spawn_ack gap request handshake with the LFSR     |
// |            field               [ROWS-1:0][COLS-1:0] pipe pixels        |
// |            bird_col            field column BIRD_COL                   |
// |            pass_pulse, active  score pulse, any-pixel-set flag         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int GAP_H    = DEF_GAP_H,
  parameter int PIPE_W   = DEF_PIPE_W,
  parameter int SPACING  = DEF_SPACING,
  parameter int BIRD_COL = DEF_BIRD_COL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    clear,
  input  logic [$clog2(ROWS)-1:0] gap_top,
  output logic                    spawn_ack,
  output logic [ROWS*COLS-1:0]    field,
  output logic [ROWS-1:0]         bird_col,
  output logic                    pass_pulse,
  output logic                    active
);

  localparam int GW = $clog2(ROWS);
  localparam int PW = $clog2(SPACING);

  logic [ROWS-1:0][COLS-1:0] r_field;
  logic [COLS-1:0]           r_lead;      // 1 marks a pipe's leading column
  logic [PW-1:0]             r_phase;
  logic [GW-1:0]             r_gap_hold;
  logic                      r_spawn_ack;
  logic                      r_pass_pulse;

  logic                      w_adv;
  logic                      w_spawn;
  logic                      w_inject_en;
  logic [GW-1:0]             w_gap_clamped;
  logic [GW-1:0]             w_gap_eff;
  logic [ROWS-1:0]           w_inject;

  assign w_adv         = tick & run & ~clear;
  assign w_spawn       = (r_phase == '0);
  assign w_inject_en   = (int'(r_phase) < PIPE_W);
  assign w_gap_clamped = GW'(clamp_gap(int'(gap_top), ROWS, GAP_H));
  // gap_top is only honoured on the leading column; the rest of the pipe
  // reuses the latched value so the gap stays straight.
  assign w_gap_eff     = w_spawn ? w_gap_clamped : r_gap_hold;

  pipe_column_gen #(
    .ROWS  (ROWS),
    .GAP_H (GAP_H)
  ) u_column_gen (
    .gap_eff (w_gap_eff),
    .enable  (w_inject_en),
    .column  (w_inject)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_field      <= '0;
      r_lead       <= '0;
      r_phase      <= '0;
      r_gap_hold   <= '0;
      r_spawn_ack  <= 1'b0;
      r_pass_pulse <= 1'b0;
    end else if (clear) begin
      r_field      <= '0;
      r_lead       <= '0;
      r_phase      <= '0;
      r_spawn_ack  <= 1'b0;
      r_pass_pulse <= 1'b0;
    end else begin
      // Pulses are qualified by adv every cycle, so a held tick still yields
      // single-cycle pulses per advance event.
      r_spawn_ack  <= w_adv & w_spawn;
      // The leading column sits at BIRD_COL-1 now and lands on BIRD_COL with
      // this shift, so the pulse lines up with the field update.
      r_pass_pulse <= w_adv & r_lead[BIRD_COL-1];
      if (w_adv) begin
        for (int r = 0; r < ROWS; r++) begin
          r_field[r] <= {r_field[r][COLS-2:0], w_inject[r]};
        end
        r_lead  <= {r_lead[COLS-2:0], w_spawn};
        r_phase <= (r_phase == PW'(SPACING - 1)) ? '0 : r_phase + PW'(1);
        if (w_spawn) begin
          r_gap_hold <= w_gap_clamped;
        end
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_bird
    assign bird_col[r] = r_field[r][BIRD_COL];
  end

  assign field      = r_field;
  assign spawn_ack  = r_spawn_ack;
  assign pass_pulse = r_pass_pulse;
  assign active     = |r_field;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scroller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_pipe_scroller                                            |
// | Purpose  : Self-checking bench for pipe_scroller. The reference model  |
// |            tracks the advance count since clear and the gap of every   |
// |            spawned pipe, and paints the expected field from pipe       |
// |            positions.                                                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_pipe_scroller;

  localparam int ROWS     = 16;
  localparam int COLS     = 16;
  localparam int GAP_H    = 4;
  localparam int PIPE_W   = 2;
  localparam int SPACING  = 6;
  localparam int BIRD_COL = 12;
  localparam int FW       = ROWS * COLS;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    tick;
  logic                    run;
  logic                    clear;
  logic [$clog2(ROWS)-1:0] gap_top;
  logic                    spawn_ack;
  logic [FW-1:0]           field;
  logic [ROWS-1:0]         bird_col;
  logic                    pass_pulse;
  logic                    active;

  pipe_scroller #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .GAP_H    (GAP_H),
    .PIPE_W   (PIPE_W),
    .SPACING  (SPACING),
    .BIRD_COL (BIRD_COL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .run        (run),
    .clear      (clear),
    .gap_top    (gap_top),
    .spawn_ack  (spawn_ack),
    .field      (field),
    .bird_col   (bird_col),
    .pass_pulse (pass_pulse),
    .active     (active)
  );

  always #5 clk = ~clk;

  // Reference model state
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;      // advances since last clear/reset
  int   gaps[$];         // clamped gap of pipe k, spawned on advance k*SPACING+1
  logic exp_spawn = 1'b0;
  logic exp_pass  = 1'b0;

  task automatic check_val(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Pipe k has its leading column at n-1-k*SPACING and spans PIPE_W columns
  // toward the entry edge.
  function automatic logic [FW-1:0] model_field();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < gaps.size(); k++) begin
      int lead;
      lead = n - 1 - k * SPACING;
      for (int c = 0; c < COLS; c++) begin
        if (c <= lead && c > lead - PIPE_W) begin
          for (int r = 0; r < ROWS; r++) begin
            if (r < gaps[k] || r >= gaps[k] + GAP_H) f[r*COLS+c] = 1'b1;
          end
        end
      end
    end
    return f;
  endfunction

  task automatic model_reset();
    n = 0;
    gaps.delete();
    exp_spawn = 1'b0;
    exp_pass  = 1'b0;
  endtask

  task automatic model_edge(input logic t, input logic r, input logic c, input int g);
    exp_spawn = 1'b0;
    exp_pass  = 1'b0;
    if (c) begin
      n = 0;
      gaps.delete();
    end else if (t && r) begin
      n++;
      if ((n - 1) % SPACING == 0) begin
        gaps.push_back((g > ROWS - GAP_H) ? ROWS - GAP_H : g);
        exp_spawn = 1'b1;
      end
      if (n - 1 - BIRD_COL >= 0 && (n - 1 - BIRD_COL) % SPACING == 0) exp_pass = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [FW-1:0]   f;
    logic [ROWS-1:0] bc;
    f = model_field();
    for (int r = 0; r < ROWS; r++) bc[r] = f[r*COLS+BIRD_COL];
    check_val("field", field, f);
    check_val("spawn_ack", FW'(spawn_ack), FW'(exp_spawn));
    check_val("pass_pulse", FW'(pass_pulse), FW'(exp_pass));
    check_val("bird_col", FW'(bird_col), FW'(bc));
    check_val("active", FW'(active), FW'(|f));
  endtask

  // Called at a negedge: drive inputs, take the edge, check at next negedge.
  task automatic do_cycle(input logic t, input logic r, input logic c, input int g);
    tick    = t;
    run     = r;
    clear   = c;
    gap_top = 4'(g);
    @(posedge clk);
    model_edge(t, r, c, g);
    @(negedge clk);
    tick  = 1'b0;
    clear = 1'b0;
    check_all();
  endtask

  function automatic logic [ROWS-1:0] dut_col(input int c);
    logic [ROWS-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r] = field[r*COLS+c];
    return v;
  endfunction

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    run     = 1'b0;
    clear   = 1'b0;
    gap_top = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // Directed scroll: gap 5 on first pipe, 3 on second, 14 (clamped) on third
    for (int i = 1; i <= 20; i++) begin
      do_cycle(1'b1, 1'b1, 1'b0, (i == 1) ? 5 : (i == 7) ? 3 : (i == 13) ? 14 : 2);
      if (i == 1) check_val("tp1_col0", FW'(dut_col(0)), FW'(16'hFE1F));
      if (i == 3) check_val("tp2_col0", FW'(dut_col(0)), FW'(16'h0000));
      if (i == 7) check_val("tp3_col0", FW'(dut_col(0)), FW'(16'hFF87));
      if (i == 13) check_val("tp4_pass", FW'(pass_pulse), FW'(1'b1));
    end
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0, 7);   // frozen
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 1'b0, 7);   // resume
    do_cycle(1'b1, 1'b1, 1'b1, 7);                               // clear beats tick
    do_cycle(1'b1, 1'b1, 1'b0, 9);                               // respawn
    do_cycle(1'b0, 1'b1, 1'b0, 9);                               // idle cycle

    // Asynchronous reset between edges
    do_cycle(1'b1, 1'b1, 1'b0, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Randomised operation
    for (int i = 0; i < 600; i++) begin
      do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 49) == 0), int'($urandom_range(0, ROWS - 1)));
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
